// File: rtl/bin2bcd4_pkg.sv
// Shared constants for the binary-to-BCD converter: FSM state codes and BCD limits.
package bin2bcd_pkg;

  localparam int unsigned BCD_MAX  = 9999;
  localparam int unsigned N_DIGITS = 4;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_CONV = 2'd1;
  localparam state_t S_DONE = 2'd2;

endpackage

// File: rtl/bin2bcd4_if.sv
// Request/result bundle between a value source and the BCD converter.
interface bin2bcd4_if #(parameter int unsigned BIN_W = 14);

  logic             start;
  logic [BIN_W-1:0] bin;
  logic             busy;
  logic             done;
  logic             ovf;
  logic [3:0]       D3;
  logic [3:0]       D2;
  logic [3:0]       D1;
  logic [3:0]       D0;

  modport master (output start, bin, input busy, done, ovf, D3, D2, D1, D0);
  modport slave  (input start, bin, output busy, done, ovf, D3, D2, D1, D0);

endinterface

// File: rtl/bin2bcd4_adj3.sv
// Double-dabble digit correction: add 3 to a BCD nibble holding 5 or more.
module bcd_adj3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  always_comb begin
    dout = (din >= 4'd5) ? din + 4'd3 : din;
  end

endmodule

// File: rtl/bin2bcd4.sv
// Sequential shift-add-3 binary-to-BCD converter; results held in output registers
// so the display only ever sees completed conversions.
module bin2bcd4
  import bin2bcd_pkg::*;
#(
  parameter int unsigned BIN_W = 14
) (
  input logic       clk,
  input logic       rst,
  bin2bcd4_if.slave io
);

  localparam int unsigned BCD_W = 4 * N_DIGITS;
  localparam int unsigned SR_W  = BCD_W + BIN_W;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [SR_W-1:0]  sr_q, sr_d;
  logic             ovf_next_q, ovf_next_d;
  logic [BCD_W-1:0] dig_q, dig_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic [BCD_W-1:0] bcd_adj;
  logic             ovf_cap;
  logic [BIN_W-1:0] sat;

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_adj
    bcd_adj3 u_adj (
      .din  (sr_q[BIN_W + 4*g +: 4]),
      .dout (bcd_adj[4*g +: 4])
    );
  end

  // Clamping to 9999 keeps the thousands digit from ever carrying out.
  always_comb begin
    ovf_cap = 32'(io.bin) > BCD_MAX;
    sat     = ovf_cap ? BIN_W'(BCD_MAX) : io.bin;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    ovf_next_d = ovf_next_q;
    dig_d      = dig_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (io.start) begin
          sr_d       = {{BCD_W{1'b0}}, sat};
          ovf_next_d = ovf_cap;
          cnt_d      = 4'(BIN_W);
          state_d    = S_CONV;
        end
      end
      S_CONV: begin
        sr_d  = {bcd_adj, sr_q[BIN_W-1:0]} << 1;
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_DONE;
      end
      S_DONE: begin
        dig_d   = sr_q[SR_W-1:BIN_W];
        ovf_d   = ovf_next_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      sr_q       <= '0;
      ovf_next_q <= 1'b0;
      dig_q      <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      ovf_next_q <= ovf_next_d;
      dig_q      <= dig_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign io.busy = busy_q;
  assign io.done = done_q;
  assign io.ovf  = ovf_q;
  assign io.D3   = dig_q[15:12];
  assign io.D2   = dig_q[11:8];
  assign io.D1   = dig_q[7:4];
  assign io.D0   = dig_q[3:0];

endmodule

// File: tb/tb_bin2bcd4.sv
// Directed-vector bench for bin2bcd4 with hand-computed BCD results.
module tb_bin2bcd4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  bin2bcd4_if #(.BIN_W(14)) bif ();

  bin2bcd4 #(.BIN_W(14)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bif.slave)
  );

  logic [15:0] dig;
  assign dig = {bif.D3, bif.D2, bif.D1, bif.D0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse start for one cycle, then wait (bounded) for done.
  task automatic run_conv(input logic [13:0] v, output int lat, output int bcyc);
    bif.bin   = v;
    bif.start = 1'b1;
    @(posedge clk); #1;
    bif.start = 1'b0;
    bcyc = bif.busy ? 1 : 0;
    lat  = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      lat++;
      if (bif.busy) bcyc++;
      if (bif.done) break;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; bif.start = 1'b0; bif.bin = '0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    checks++; if (dig !== 16'h0000) begin errors++; $display("FAIL reset_digits got %h want 0000", dig); end
    checks++; if (bif.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bif.busy); end
    checks++; if (bif.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bif.done); end
    checks++; if (bif.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", bif.ovf); end
  endtask

  task automatic test_basic;
    int lat, bcyc;
    run_conv(14'd1234, lat, bcyc);
    checks++; if (lat !== 15) begin errors++; $display("FAIL basic_latency got %0d want 15", lat); end
    checks++; if (bcyc !== 15) begin errors++; $display("FAIL basic_busy_cycles got %0d want 15", bcyc); end
    checks++; if (dig !== 16'h1234) begin errors++; $display("FAIL basic_digits got %h want 1234", dig); end
    checks++; if (bif.ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf got %b want 0", bif.ovf); end
    checks++; if (bif.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done got %b want 0", bif.busy); end
    @(posedge clk); #1;
    checks++; if (bif.done !== 1'b0) begin errors++; $display("FAIL basic_done_width got %b want 0", bif.done); end
  endtask

  task automatic test_boundaries;
    int lat, bcyc;
    run_conv(14'd0, lat, bcyc);
    checks++; if (dig !== 16'h0000 || bif.ovf !== 1'b0) begin errors++; $display("FAIL zero got %h ovf %b want 0000 ovf 0", dig, bif.ovf); end
    run_conv(14'd9999, lat, bcyc);
    checks++; if (dig !== 16'h9999 || bif.ovf !== 1'b0) begin errors++; $display("FAIL max got %h ovf %b want 9999 ovf 0", dig, bif.ovf); end
    run_conv(14'd12000, lat, bcyc);
    checks++; if (dig !== 16'h9999 || bif.ovf !== 1'b1) begin errors++; $display("FAIL clamp got %h ovf %b want 9999 ovf 1", dig, bif.ovf); end
    run_conv(14'd10000, lat, bcyc);
    checks++; if (dig !== 16'h9999 || bif.ovf !== 1'b1) begin errors++; $display("FAIL clamp_edge got %h ovf %b want 9999 ovf 1", dig, bif.ovf); end
    // ovf must stay set while the next conversion runs
    bif.bin = 14'd42; bif.start = 1'b1;
    @(posedge clk); #1; bif.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (bif.ovf !== 1'b1) begin errors++; $display("FAIL ovf_hold got %b want 1", bif.ovf); end
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bif.done) break;
    end
    checks++; if (dig !== 16'h0042 || bif.ovf !== 1'b0) begin errors++; $display("FAIL small got %h ovf %b want 0042 ovf 0", dig, bif.ovf); end
    run_conv(14'd5678, lat, bcyc);
    checks++; if (dig !== 16'h5678) begin errors++; $display("FAIL mid got %h want 5678", dig); end
  endtask

  task automatic test_ignore_busy;
    int ndone, first, held_bad;
    ndone = 0; first = -1; held_bad = 0;
    bif.bin = 14'd1234; bif.start = 1'b1;
    @(posedge clk); #1; bif.start = 1'b0;
    bif.bin = 14'd3333;
    for (int i = 1; i <= 30; i++) begin
      if (i == 5) begin bif.bin = 14'd5678; bif.start = 1'b1; end
      @(posedge clk); #1;
      bif.start = 1'b0;
      if (bif.done) begin ndone++; if (first < 0) first = i; end
      if (first < 0 && dig !== 16'h5678) held_bad++;
    end
    checks++; if (ndone !== 1) begin errors++; $display("FAIL ignore_done_count got %0d want 1", ndone); end
    checks++; if (first !== 15) begin errors++; $display("FAIL ignore_latency got %0d want 15", first); end
    checks++; if (dig !== 16'h1234) begin errors++; $display("FAIL ignore_digits got %h want 1234", dig); end
    checks++; if (held_bad !== 0) begin errors++; $display("FAIL ignore_hold got %0d changes want 0", held_bad); end
  endtask

  task automatic test_reset_mid;
    int lat, bcyc, ndone;
    ndone = 0;
    bif.bin = 14'd9876; bif.start = 1'b1;
    @(posedge clk); #1; bif.start = 1'b0;
    repeat (6) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    checks++; if (dig !== 16'h0000 || bif.ovf !== 1'b0) begin errors++; $display("FAIL midrst_outputs got %h ovf %b want 0000 ovf 0", dig, bif.ovf); end
    checks++; if (bif.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", bif.busy); end
    for (int i = 0; i < 20; i++) begin
      if (bif.done) ndone++;
      @(posedge clk); #1;
    end
    checks++; if (ndone !== 0) begin errors++; $display("FAIL midrst_no_done got %0d want 0", ndone); end
    run_conv(14'd77, lat, bcyc);
    checks++; if (lat !== 15 || dig !== 16'h0077) begin errors++; $display("FAIL midrst_after got %h lat %0d want 0077 lat 15", dig, lat); end
  endtask

  task automatic test_back_to_back;
    int lat, bcyc, gap, held_bad;
    held_bad = 0; gap = 0;
    run_conv(14'd1111, lat, bcyc);
    checks++; if (dig !== 16'h1111 || lat !== 15) begin errors++; $display("FAIL b2b_first got %h lat %0d want 1111 lat 15", dig, lat); end
    bif.bin = 14'd2222; bif.start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      bif.start = 1'b0;
      gap++;
      if (bif.done) break;
      if (dig !== 16'h1111) held_bad++;
    end
    checks++; if (gap !== 16) begin errors++; $display("FAIL b2b_gap got %0d want 16", gap); end
    checks++; if (held_bad !== 0) begin errors++; $display("FAIL b2b_hold got %0d changes want 0", held_bad); end
    checks++; if (dig !== 16'h2222) begin errors++; $display("FAIL b2b_second got %h want 2222", dig); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bif.start = 1'b0;
    bif.bin = '0;
    test_reset;
    test_basic;
    test_boundaries;
    test_ignore_busy;
    test_reset_mid;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bin2bcd4.md
# bin2bcd4

Sequential binary-to-BCD converter that feeds the four-digit 7-segment scanner. It accepts a binary value (sensor reading, counter) on a start strobe and converts it with a shift-add-3 (double-dabble) loop. It then presents four BCD nibbles on registered outputs that connect directly to the scanner's D3..D0 inputs. The outputs hold the previous result for the whole conversion, so the display never shows intermediate values.

## Interface
- BIN_W, 14, binary input width; legal range 4..14; also the number of shift iterations.
- clk  input  1  system clock; the same clock drives the scanner.
- rst  input  1  reset; one clock, reset is synchronous and active-high.
- start  input  1  conversion request; sampled only in IDLE.
- bin  input  BIN_W  unsigned value; captured on the accepted start edge.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse; new D3..D0/ovf valid from this cycle.
- ovf  output  1  last accepted bin exceeded 9999; held until next done.
- D3  output  4  thousands digit, BCD 0..9.
- D2  output  4  hundreds digit.
- D1  output  4  tens digit.
- D0  output  4  units digit.

## Operation
- States: IDLE, CONV, DONE.
- IDLE:
  - On start=1, capture sat = min(bin, 9999) into the low bits of a shift register, with the BCD field = 0.
  - Capture ovf_next = (bin > 9999).
  - Load iteration counter = BIN_W, then go to CONV.
- CONV: each cycle runs one step, then decrements the counter.
  - For each of the 4 BCD nibbles, add 3 if the nibble is 5 or more.
  - Shift the whole {bcd, bin} register left by 1.
  - When the counter reaches 0 after the step, go to DONE.
- DONE:
  - Load D3..D0 from the BCD field and ovf from ovf_next.
  - Pulse done, then go to IDLE.
- Arithmetic:
  - BCD field is 16 bits; the clamp guarantees no carry out of D3.
  - Each add-3 works on one nibble only, with no inter-nibble carry.
- start while busy=1 is ignored, not queued.
- start in the cycle done is high is accepted, because the state is already IDLE.
- bin changes after capture have no effect.
- Outputs D3..D0 and ovf change only on the DONE edge.
- Reset values: state IDLE, busy=0, done=0, ovf=0, D3=D2=D1=D0=0.
- Reset mid-conversion aborts the conversion; outputs return to their reset values and no done pulse is issued.

## Timing
- Edge k: start accepted; busy=1 from k+1.
- Edges k+1 .. k+BIN_W: shift steps; state=DONE after edge k+BIN_W.
- Edge k+BIN_W+1: D3..D0/ovf updated, done=1, busy=0.
- Total latency: start edge to done visible = BIN_W+1 cycles; 15 for BIN_W=14.
- busy is high for exactly BIN_W+1 cycles per conversion.
- done is high for exactly 1 cycle.
- Maximum throughput: one conversion every BIN_W+2 cycles (back-to-back start on the done cycle).
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package bin2bcd_pkg holds:
  - the state enum (IDLE, CONV, DONE);
  - BCD_MAX = 9999;
  - N_DIGITS = 4.
- Sub-module bcd_adj3: 4-bit combinational "add 3 if ≥5"; instantiate one per digit.
- Top level contains the FSM, iteration counter, shift register, clamp comparator, and output registers.

## Test plan
- Reset, then bin=1234, start for 1 cycle:
  - busy high for 15 cycles;
  - done at start+15;
  - D3..D0 = 1,2,3,4; ovf=0.
- bin=0, then bin=9999: outputs 0,0,0,0 and 9,9,9,9; ovf=0 in both.
- bin=12000: outputs 9,9,9,9 with ovf=1. A following bin=42 clears ovf and gives 0,0,4,2.
- Start 1234, then pulse start with bin=5678 at start+5:
  - the second start is ignored;
  - a single done; result is 1,2,3,4.
- Start 1234, then assert rst at start+7:
  - all outputs 0; busy=0; no done.
  - A new start with 77 then gives 0,0,7,7 after 15 cycles.
- Back-to-back: start with 1111, hold start=1 with bin=2222 on the done cycle:
  - the second done comes 16 cycles after the first;
  - D3..D0 hold 1,1,1,1 until that done, then show 2,2,2,2.
